inst_fetch_mem: RTL and testbench

Parametrised, writable instruction memory with a request/response fetch handshake, a configurable number of wait states, and flush support. It replaces the combinational instruction ROM in the single-cycle datapath and is the fetch-side memory for the pipelined core. The PC stage issues word fetches. Branch and jump logic can cancel an in-flight fetch. A program port loads the array at run time, so test programs no longer need to be hard-coded.

---
 rtl/inst_fetch_mem.sv | 146 ++++++++++++++
 tb/tb_inst_fetch_mem.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: writable instruction memory with a request/response fetch
// handshake, WAIT_STATES extra latency cycles, flush, and a program port.
//
// Parameters:
//   DEPTH_LOG2   log2 of the number of 32-bit words
//   WAIT_STATES  extra cycles between accept and response (0..15)
//   FAULT_INST   word returned on a misaligned or out-of-range fetch
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req, addr              fetch request and byte address (sampled on accept)
//   ready                  a fetch can be accepted this cycle
//   rvalid, inst, fault    response strobe, fetched word, fault flag
//   flush                  cancel any pending fetch
//   prog_we/addr/data      program-port word write, always accepted
module inst_fetch_mem #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] FAULT_INST  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [31:0]           addr,
  output logic                  ready,
  output logic                  rvalid,
  output logic [31:0]           inst,
  output logic                  fault,
  input  logic                  flush,
  input  logic                  prog_we,
  input  logic [DEPTH_LOG2-1:0] prog_addr,
  input  logic [31:0]           prog_data
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_misalign;
  logic                  r_oor;
  logic [31:0]           r_inst;
  logic                  r_fault;

  logic [31:0] r_mem [DEPTH] = '{default: '0};

  logic                  w_accept;
  logic                  w_enter_resp;
  logic [DEPTH_LOG2-1:0] w_addr_idx;
  logic                  w_addr_misalign;
  logic                  w_addr_oor;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_rd_fault;

  assign w_addr_idx      = addr[DEPTH_LOG2+1:2];
  assign w_addr_misalign = (addr[1:0] != 2'b00);
  assign w_addr_oor      = (addr[31:DEPTH_LOG2+2] != '0);

  assign ready    = ((r_state == S_IDLE) || (r_state == S_RESP)) && !flush;
  assign rvalid   = (r_state == S_RESP) && !flush;
  assign w_accept = req && ready;
  assign inst     = r_inst;
  assign fault    = r_fault;

  // With WAIT_STATES==0 the RESP-entry edge is the accept edge itself, so the
  // read must use the live address rather than the not-yet-latched copy.
  assign w_rd_idx   = (r_state == S_WAIT) ? r_idx : w_addr_idx;
  assign w_rd_fault = (r_state == S_WAIT) ? (r_misalign || r_oor)
                                          : (w_addr_misalign || w_addr_oor);

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    if (flush) begin
      w_next     = S_IDLE;
      w_cnt_next = '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            if (WAIT_STATES == 0) begin
              w_next       = S_RESP;
              w_enter_resp = 1'b1;
            end else begin
              w_next     = S_WAIT;
              w_cnt_next = CNT_INIT;
            end
          end else begin
            w_next = S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_misalign <= 1'b0;
      r_oor      <= 1'b0;
      r_inst     <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_idx      <= w_addr_idx;
        r_misalign <= w_addr_misalign;
        r_oor      <= w_addr_oor;
      end
      if (w_enter_resp) begin
        r_fault <= w_rd_fault;
        r_inst  <= w_rd_fault ? FAULT_INST : r_mem[w_rd_idx];
      end
    end
  end

  // Array is not reset; a same-edge write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_mem.sv
module tb_inst_fetch_mem;

  localparam int NI = 5;  // instance g runs with WAIT_STATES = g

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [NI-1:0] req = '0, flush = '0, prog_we = '0;
  logic [NI-1:0] ready, rvalid, fault;
  logic [31:0] addr [NI];
  logic [31:0] prog_data [NI];
  logic [7:0]  prog_addr [NI];
  logic [31:0] inst [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inst_fetch_mem #(
      .DEPTH_LOG2 (8),
      .WAIT_STATES(g),
      .FAULT_INST (32'h0000_0000)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req[g]),
      .addr     (addr[g]),
      .ready    (ready[g]),
      .rvalid   (rvalid[g]),
      .inst     (inst[g]),
      .fault    (fault[g]),
      .flush    (flush[g]),
      .prog_we  (prog_we[g]),
      .prog_addr(prog_addr[g]),
      .prog_data(prog_data[g])
    );
  end

  task automatic chk(input string name, input int g, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h, expected %h at %0t", name, g, got, exp, $time);
    end
  endtask

  // Reference model: each accepted fetch is due at edge (accept edge + WS);
  // until then the block is busy, and the cycle after the due edge is the
  // response cycle carrying the word the array held just before that edge.
  bit [31:0] mem_m   [NI][256];
  bit        m_pend  [NI];
  int        m_due   [NI];
  bit [7:0]  m_idx   [NI];
  bit        m_flt   [NI];
  bit        m_resp  [NI];
  bit [31:0] m_inst  [NI];
  bit        m_fault [NI];
  int        ecount = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NI; g++) begin
        m_pend[g]  = 1'b0;
        m_resp[g]  = 1'b0;
        m_inst[g]  = '0;
        m_fault[g] = 1'b0;
      end
    end else begin
      ecount++;
      for (int g = 0; g < NI; g++) begin
        bit can_take;
        can_take = !m_pend[g] && !flush[g];
        m_resp[g] = 1'b0;
        if (flush[g]) begin
          m_pend[g] = 1'b0;
        end else begin
          if (req[g] && can_take) begin
            m_pend[g] = 1'b1;
            m_due[g]  = ecount + g;
            m_idx[g]  = addr[g][9:2];
            m_flt[g]  = (addr[g][1:0] != 0) || (addr[g][31:10] != 0);
          end
          if (m_pend[g] && m_due[g] == ecount) begin
            m_pend[g]  = 1'b0;
            m_resp[g]  = 1'b1;
            m_fault[g] = m_flt[g];
            m_inst[g]  = m_flt[g] ? 32'h0 : mem_m[g][m_idx[g]];
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++)
      if (prog_we[g]) mem_m[g][prog_addr[g]] <= prog_data[g];
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      chk("ready",  g, 32'(ready[g]),  32'(!m_pend[g] && !flush[g]));
      chk("rvalid", g, 32'(rvalid[g]), 32'(m_resp[g] && !flush[g]));
      chk("inst",   g, inst[g],        m_inst[g]);
      chk("fault",  g, 32'(fault[g]),  32'(m_fault[g]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int g, input int idx, input logic [31:0] d);
    prog_we[g]   = 1'b1;
    prog_addr[g] = idx[7:0];
    prog_data[g] = d;
    tick();
    prog_we[g] = 1'b0;
  endtask

  logic [31:0] words2 [3];

  initial begin
    for (int g = 0; g < NI; g++) begin
      addr[g] = '0;
      prog_addr[g] = '0;
      prog_data[g] = '0;
    end
    #1 rst_n = 1'b0;
    tick();
    tick();
    for (int g = 0; g < NI; g++) begin
      chk("rst_ready", g, 32'(ready[g]), 32'd1);
      chk("rst_rvalid", g, 32'(rvalid[g]), 32'd0);
      chk("rst_inst", g, inst[g], 32'd0);
      chk("rst_fault", g, 32'(fault[g]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Load and fetch, zero wait states
    wr(0, 1, 32'h8c1f0000);
    req[0] = 1'b1; addr[0] = 32'h4;
    tick();
    req[0] = 1'b0;
    chk("t1_rvalid", 0, 32'(rvalid[0]), 32'd1);
    chk("t1_inst", 0, inst[0], 32'h8c1f0000);
    chk("t1_fault", 0, 32'(fault[0]), 32'd0);
    chk("t1_ready", 0, 32'(ready[0]), 32'd1);
    tick();

    // Faults, back-to-back with zero wait states
    wr(0, 0, 32'haaaa5555);
    wr(0, 255, 32'h12345678);
    req[0] = 1'b1; addr[0] = 32'h6;
    tick();
    chk("t3_mis_rvalid", 0, 32'(rvalid[0]), 32'd1);
    chk("t3_mis_inst", 0, inst[0], 32'h0);
    chk("t3_mis_fault", 0, 32'(fault[0]), 32'd1);
    addr[0] = 32'h400;
    tick();
    chk("t3_oor_inst", 0, inst[0], 32'h0);
    chk("t3_oor_fault", 0, 32'(fault[0]), 32'd1);
    addr[0] = 32'h3fc;
    tick();
    chk("t3_top_inst", 0, inst[0], 32'h12345678);
    chk("t3_top_fault", 0, 32'(fault[0]), 32'd0);
    addr[0] = 32'h0;
    tick();
    req[0] = 1'b0;
    chk("t3_w0_inst", 0, inst[0], 32'haaaa5555);
    tick();

    // Back-to-back, two wait states
    words2[0] = 32'h8c1f0000; words2[1] = 32'h001ff022; words2[2] = 32'h021fe820;
    for (int i = 0; i < 3; i++) wr(2, i + 1, words2[i]);
    req[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr[2] = 32'(4 * (i + 1));
      tick();
      chk("t2_wait_ready", 2, 32'(ready[2]), 32'd0);
      chk("t2_wait_rvalid", 2, 32'(rvalid[2]), 32'd0);
      tick();
      chk("t2_wait_ready", 2, 32'(ready[2]), 32'd0);
      tick();
      chk("t2_rvalid", 2, 32'(rvalid[2]), 32'd1);
      chk("t2_inst", 2, inst[2], words2[i]);
    end
    req[2] = 1'b0;
    tick();

    // Flush during WAIT, then a clean fetch; then flush during RESP
    wr(3, 13, 32'h11111111);
    wr(3, 19, 32'h22222222);
    req[3] = 1'b1; addr[3] = 32'h34;
    tick();
    req[3] = 1'b0;
    tick();
    flush[3] = 1'b1; req[3] = 1'b1; addr[3] = 32'h4c;
    #1;
    chk("t4_flush_ready", 3, 32'(ready[3]), 32'd0);
    chk("t4_flush_rvalid", 3, 32'(rvalid[3]), 32'd0);
    tick();
    flush[3] = 1'b0; req[3] = 1'b0;
    #1;
    chk("t4_idle_ready", 3, 32'(ready[3]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_no_rvalid", 3, 32'(rvalid[3]), 32'd0);
    end
    req[3] = 1'b1; addr[3] = 32'h4c;
    tick();
    req[3] = 1'b0;
    tick();
    tick();
    chk("t4_early_rvalid", 3, 32'(rvalid[3]), 32'd0);
    tick();
    chk("t4_rvalid", 3, 32'(rvalid[3]), 32'd1);
    chk("t4_inst", 3, inst[3], 32'h22222222);
    flush[3] = 1'b1;
    #1;
    chk("t4_resp_flush_rvalid", 3, 32'(rvalid[3]), 32'd0);
    tick();
    flush[3] = 1'b0;
    tick();

    // Write collisions, one wait state
    wr(1, 3, 32'h33333333);
    req[1] = 1'b1; addr[1] = 32'hc;
    prog_we[1] = 1'b1; prog_addr[1] = 8'd3; prog_data[1] = 32'hdeadbeef;
    tick();
    req[1] = 1'b0; prog_we[1] = 1'b0;
    chk("t5_wait_rvalid", 1, 32'(rvalid[1]), 32'd0);
    tick();
    chk("t5_new_rvalid", 1, 32'(rvalid[1]), 32'd1);
    chk("t5_new_inst", 1, inst[1], 32'hdeadbeef);
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    prog_we[1] = 1'b1; prog_addr[1] = 8'd3; prog_data[1] = 32'h55555555;
    tick();
    prog_we[1] = 1'b0;
    chk("t5_old_inst", 1, inst[1], 32'hdeadbeef);
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    tick();
    chk("t5_after_inst", 1, inst[1], 32'h55555555);
    tick();

    // Reset during WAIT, four wait states
    wr(4, 5, 32'h66666666);
    req[4] = 1'b1; addr[4] = 32'h14;
    tick();
    req[4] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 4, 32'(ready[4]), 32'd1);
    chk("t6_rst_rvalid", 4, 32'(rvalid[4]), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_no_rvalid", 4, 32'(rvalid[4]), 32'd0);
    end
    req[4] = 1'b1;
    tick();
    req[4] = 1'b0;
    repeat (3) tick();
    chk("t6_early_rvalid", 4, 32'(rvalid[4]), 32'd0);
    tick();
    chk("t6_rvalid", 4, 32'(rvalid[4]), 32'd1);
    chk("t6_inst", 4, inst[4], 32'h66666666);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
